park_lot_ctrl: RTL and testbench

Multi-slot parking-lot controller: the parametrised successor of the single-space park controller. It tracks NUM_SLOTS spaces, each FREE, RESERVED or OCCUPIED. A debounced reserve button books a space for a bounded hold time, and per-slot car sensors drive occupancy and release. It drives active-low RGB LEDs per slot plus lot-level status, and sits between the board buttons/sensors and the LED pins.

---
 rtl/park_lot_ctrl.sv | 155 +++++++++++++++
 tb/tb_park_lot_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/park_lot_ctrl.sv
// Multi-slot parking-lot controller: per-slot FREE/RESERVED/OCCUPIED tracking,
// debounced reserve requests with a bounded hold time, active-low RGB LEDs.
//
// state      | meaning
// S_FREE     | space open, may be booked or walked into
// S_RESERVED | booked, hold timer counting down to expiry
// S_OCCUPIED | car present on the sensor
module park_lot_ctrl #(
  parameter int NUM_SLOTS   = 4,
  parameter int HOLD_CYCLES = 270_000_000,
  parameter bit AUTO_ASSIGN = 1'b0,
  parameter int SEL_W       = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
  parameter int CNT_W       = $clog2(NUM_SLOTS + 1)
) (
  input  logic                 clk,
  input  logic                 reset_button,
  input  logic                 reserve_button,
  input  logic [SEL_W-1:0]     slot_sel,
  input  logic [NUM_SLOTS-1:0] car_present,
  output logic                 reserve_ack,
  output logic                 reserve_nack,
  output logic [SEL_W-1:0]     granted_slot,
  output logic [NUM_SLOTS-1:0] expired,
  output logic [NUM_SLOTS-1:0] red_led,
  output logic [NUM_SLOTS-1:0] green_led,
  output logic [NUM_SLOTS-1:0] blue_led,
  output logic [CNT_W-1:0]     free_count,
  output logic                 lot_full
);

  localparam int TMR_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {S_FREE, S_RESERVED, S_OCCUPIED} slot_state_t;

  slot_state_t          state_q [NUM_SLOTS];
  slot_state_t          state_d [NUM_SLOTS];
  logic [TMR_W-1:0]     timer_q [NUM_SLOTS];
  logic [TMR_W-1:0]     timer_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] expired_d;
  logic [NUM_SLOTS-1:0] eligible;

  logic             btn_meta, btn_sync, btn_prev, req_q;
  logic             grant_hit, grant;
  logic [SEL_W-1:0] grant_idx;

  // Registered edge pulse keeps the request three edges behind the first sample.
  always_ff @(posedge clk or posedge reset_button) begin
    if (reset_button) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
      btn_prev <= 1'b0;
      req_q    <= 1'b0;
    end else begin
      btn_meta <= reserve_button;
      btn_sync <= btn_meta;
      btn_prev <= btn_sync;
      req_q    <= btn_sync & ~btn_prev;
    end
  end

  always_comb begin
    eligible  = '0;
    grant_hit = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      eligible[i] = (state_q[i] == S_FREE) && !car_present[i];
    if (AUTO_ASSIGN) begin
      // Descending scan so the lowest eligible index wins.
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
        if (eligible[i]) begin
          grant_hit = 1'b1;
          grant_idx = SEL_W'(i);
        end
      end
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (slot_sel == SEL_W'(i) && eligible[i]) begin
          grant_hit = 1'b1;
          grant_idx = slot_sel;
        end
      end
    end
    grant = req_q & grant_hit;
  end

  always_comb begin
    expired_d = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
      unique case (state_q[i])
        S_FREE: begin
          if (car_present[i]) begin
            state_d[i] = S_OCCUPIED;
          end else if (grant && grant_idx == SEL_W'(i)) begin
            state_d[i] = S_RESERVED;
            timer_d[i] = TMR_LOAD;
          end
        end
        S_RESERVED: begin
          if (car_present[i]) begin
            state_d[i] = S_OCCUPIED;
          end else if (timer_q[i] == '0) begin
            state_d[i]   = S_FREE;
            expired_d[i] = 1'b1;
          end else begin
            timer_d[i] = timer_q[i] - TMR_W'(1);
          end
        end
        S_OCCUPIED: begin
          if (!car_present[i]) state_d[i] = S_FREE;
        end
        default: state_d[i] = S_FREE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset_button) begin
    if (reset_button) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state_q[i] <= S_FREE;
        timer_q[i] <= '0;
      end
      reserve_ack  <= 1'b0;
      reserve_nack <= 1'b0;
      expired      <= '0;
      granted_slot <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
      end
      reserve_ack  <= grant;
      reserve_nack <= req_q & ~grant_hit;
      expired      <= expired_d;
      if (grant) granted_slot <= grant_idx;
    end
  end

  always_comb begin
    red_led    = '1;
    green_led  = '1;
    blue_led   = '1;
    free_count = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      red_led[i]   = (state_q[i] != S_OCCUPIED);
      green_led[i] = (state_q[i] != S_FREE);
      blue_led[i]  = (state_q[i] != S_RESERVED);
      if (state_q[i] == S_FREE) free_count = free_count + CNT_W'(1);
    end
    lot_full = (free_count == '0);
  end

endmodule

// File: tb/tb_park_lot_ctrl.sv
// Scoreboard bench: two controllers (manual 5-slot, auto-assign 4-slot) share
// stimulus; a slot-level reference model predicts every cycle's outputs.
module tb_park_lot_ctrl;
  localparam int HOLD = 8;

  logic       clk = 1'b0;
  logic       reset_button, reserve_button;
  logic [2:0] slot_sel;
  logic [4:0] car_present;

  logic       ack0, nack0, full0;
  logic [2:0] gs0, fc0;
  logic [4:0] exp0, r0, g0, b0;
  logic       ack1, nack1, full1;
  logic [1:0] gs1;
  logic [2:0] fc1;
  logic [3:0] exp1, r1, g1, b1;

  park_lot_ctrl #(.NUM_SLOTS(5), .HOLD_CYCLES(HOLD), .AUTO_ASSIGN(1'b0)) u0 (
    .clk(clk), .reset_button(reset_button), .reserve_button(reserve_button),
    .slot_sel(slot_sel), .car_present(car_present),
    .reserve_ack(ack0), .reserve_nack(nack0), .granted_slot(gs0), .expired(exp0),
    .red_led(r0), .green_led(g0), .blue_led(b0), .free_count(fc0), .lot_full(full0));

  park_lot_ctrl #(.NUM_SLOTS(4), .HOLD_CYCLES(HOLD), .AUTO_ASSIGN(1'b1)) u1 (
    .clk(clk), .reset_button(reset_button), .reserve_button(reserve_button),
    .slot_sel(slot_sel[1:0]), .car_present(car_present[3:0]),
    .reserve_ack(ack1), .reserve_nack(nack1), .granted_slot(gs1), .expired(exp1),
    .red_led(r1), .green_led(g1), .blue_led(b1), .free_count(fc1), .lot_full(full1));

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ack;
    logic       nack;
    logic [2:0] gslot;
    logic [4:0] exp;
    logic [4:0] r;
    logic [4:0] g;
    logic [4:0] b;
    logic [2:0] fc;
    logic       full;
  } snap_t;

  snap_t q0[$];
  snap_t q1[$];
  int tests = 0;
  int fails = 0;

  // Reference model: 0 = free, 1 = reserved, 2 = occupied; reservations end at a deadline cycle.
  int         st[2][5];
  int         deadline[2][5];
  int         last_g[2];
  int         cyc = 0;
  logic [4:0] sh = '0;

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 5; i++) begin
        st[d][i] = 0;
        deadline[d][i] = 0;
      end
      last_g[d] = 0;
    end
    sh = '0;
    q0.delete();
    q1.delete();
  endtask

  task automatic step_dut(input int d, input logic req);
    int n, tgt, free_n;
    snap_t s;
    n = (d == 0) ? 5 : 4;
    tgt = -1;
    s = '0;
    if (req) begin
      if (d == 1) begin
        for (int i = 0; i < n; i++)
          if (tgt < 0 && st[d][i] == 0 && !car_present[i]) tgt = i;
      end else if (int'(slot_sel) < n) begin
        if (st[d][slot_sel] == 0 && !car_present[slot_sel]) tgt = int'(slot_sel);
      end
      if (tgt >= 0) begin
        s.ack = 1'b1;
        last_g[d] = tgt;
      end else begin
        s.nack = 1'b1;
      end
    end
    free_n = 0;
    for (int i = 0; i < n; i++) begin
      case (st[d][i])
        0: if (car_present[i]) st[d][i] = 2;
           else if (i == tgt) begin
             st[d][i] = 1;
             deadline[d][i] = cyc + HOLD;
           end
        1: if (car_present[i]) st[d][i] = 2;
           else if (cyc == deadline[d][i]) begin
             st[d][i] = 0;
             s.exp[i] = 1'b1;
           end
        default: if (!car_present[i]) st[d][i] = 0;
      endcase
      s.r[i] = (st[d][i] != 2);
      s.g[i] = (st[d][i] != 0);
      s.b[i] = (st[d][i] != 1);
      if (st[d][i] == 0) free_n++;
    end
    s.gslot = 3'(last_g[d]);
    s.fc    = 3'(free_n);
    s.full  = (free_n == 0);
    if (d == 0) q0.push_back(s);
    else q1.push_back(s);
  endtask

  always @(posedge clk) begin
    if (reset_button) begin
      model_reset();
    end else begin
      cyc++;
      sh = {sh[3:0], reserve_button};
      step_dut(0, sh[3] & ~sh[4]);
      step_dut(1, sh[3] & ~sh[4]);
    end
  end

  task automatic check_snap(input int d, input snap_t a);
    snap_t e;
    tests++;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      fails++;
      $display("FAIL u%0d cyc=%0d snapshot: DUT output with no expected entry", d, cyc);
      return;
    end
    if (d == 0) e = q0.pop_front();
    else e = q1.pop_front();
    if (a !== e) begin
      fails++;
      $display("FAIL u%0d cyc=%0d snapshot got ack=%b nack=%b gs=%0d exp=%b r=%b g=%b b=%b fc=%0d full=%b expected ack=%b nack=%b gs=%0d exp=%b r=%b g=%b b=%b fc=%0d full=%b",
               d, cyc, a.ack, a.nack, a.gslot, a.exp, a.r, a.g, a.b, a.fc, a.full,
               e.ack, e.nack, e.gslot, e.exp, e.r, e.g, e.b, e.fc, e.full);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_button) begin
      check_snap(0, {ack0, nack0, gs0, exp0, r0, g0, b0, fc0, full0});
      check_snap(1, {ack1, nack1, 1'b0, gs1, 1'b0, exp1, 1'b0, r1, 1'b0, g1, 1'b0, b1, fc1, full1});
    end
  end

  task automatic cyc_wait(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic expect_bits(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Asynchronous reset: outputs must clear before any clock edge arrives.
  task automatic do_reset();
    @(negedge clk);
    #2 reset_button = 1'b1;
    #1;
    expect_bits("reset_leds_u0", {r0, g0, b0}, {5'b11111, 5'b00000, 5'b11111});
    expect_bits("reset_leds_u1", {r1, g1, b1}, {4'b1111, 4'b0000, 4'b1111});
    expect_bits("reset_count_u0", {fc0, full0}, {3'd5, 1'b0});
    expect_bits("reset_count_u1", {fc1, full1}, {3'd4, 1'b0});
    expect_bits("reset_pulses", {ack0, nack0, exp0, ack1, nack1, exp1}, '0);
    expect_bits("reset_granted", {gs0, gs1}, '0);
    repeat (2) @(negedge clk);
    #2 reset_button = 1'b0;
    cyc_wait(1);
  endtask

  task automatic press(input logic [2:0] sel, input int hold, input int gap);
    slot_sel = sel;
    reserve_button = 1'b1;
    cyc_wait(hold);
    reserve_button = 1'b0;
    cyc_wait(gap);
  endtask

  initial begin
    reset_button   = 1'b1;
    reserve_button = 1'b0;
    slot_sel       = '0;
    car_present    = '0;
    @(negedge clk);
    #2 reset_button = 1'b0;
    cyc_wait(3);

    press(3'd2, 1, 4);
    cyc_wait(14);

    press(3'd1, 1, 4);
    cyc_wait(2);
    car_present[1] = 1'b1;
    cyc_wait(4);
    car_present[1] = 1'b0;
    cyc_wait(12);

    car_present[3] = 1'b1;
    cyc_wait(2);
    press(3'd3, 1, 5);
    press(3'd5, 1, 5);
    slot_sel = 3'd4;
    reserve_button = 1'b1;
    cyc_wait(3);
    car_present[4] = 1'b1;
    reserve_button = 1'b0;
    cyc_wait(4);
    car_present = '0;
    cyc_wait(12);

    car_present[0] = 1'b1;
    cyc_wait(2);
    repeat (4) press(3'd0, 1, 1);
    cyc_wait(14);
    car_present = '0;
    cyc_wait(2);

    press(3'd1, 50, 4);
    press(3'd1, 1, 12);

    press(3'd0, 1, 4);
    do_reset();
    cyc_wait(12);

    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 5) == 0) reserve_button = ~reserve_button;
      if (!reserve_button && $urandom_range(0, 3) == 0) slot_sel = 3'($urandom_range(0, 7));
      for (int i = 0; i < 5; i++)
        if ($urandom_range(0, 19) == 0) car_present[i] = ~car_present[i];
      if (k == 1500) do_reset();
      cyc_wait(1);
    end
    reserve_button = 1'b0;
    cyc_wait(3);
    expect_bits("queue_drained", {q0.size(), q1.size()}, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
